// File: rtl/ieeedrv_img_server.sv
// rtl/ieeedrv_img_server.sv - image-side block server for the IEEE drive sd_* interface
// Streams 256-byte blocks between a byte-addressed image memory and the drive track buffer.
module ieeedrv_img_server #(
  parameter int SUBDRV = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [SUBDRV-1:0] img_present,
  input  logic [31:0]       sd_lba [SUBDRV],
  input  logic [5:0]        sd_blk_cnt [SUBDRV],
  input  logic [SUBDRV-1:0] sd_rd,
  input  logic [SUBDRV-1:0] sd_wr,
  output logic [SUBDRV-1:0] sd_ack,
  output logic [12:0]       sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din [SUBDRV],
  output logic              sd_buff_wr,
  output logic [25:0]       mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready
);

  typedef enum logic [2:0] {
    IDLE, START, RD_REQ, RD_PUT, WR_ADDR, WR_SAMPLE, WR_WAIT, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  sel;
  logic [1:0]  last;
  logic        dir_wr;
  logic        present;
  logic [15:0] lba;
  logic [6:0]  cnt;
  logic [12:0] off;
  logic [5:0]  blk;
  logic [7:0]  rdata;
  logic [7:0]  wdata;

  logic        busy;
  logic        adv;
  logic        last_byte;
  logic        grant_ok;
  logic [1:0]  grant_idx;

  // Per-drive inputs padded to four entries so a 2-bit index is always in range.
  logic [3:0]  pend4;
  logic [3:0]  rd4;
  logic [3:0]  pres4;
  logic [15:0] lba4 [4];
  logic [5:0]  cnt4 [4];
  logic [7:0]  din4 [4];
  logic [15:0] unused_lba_hi [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_pad
    if (gi < SUBDRV) begin : g_real
      assign pend4[gi]         = sd_rd[gi] | sd_wr[gi];
      assign rd4[gi]           = sd_rd[gi];
      assign pres4[gi]         = img_present[gi];
      assign lba4[gi]          = sd_lba[gi][15:0];
      assign unused_lba_hi[gi] = sd_lba[gi][31:16];
      assign cnt4[gi]          = sd_blk_cnt[gi];
      assign din4[gi]          = sd_buff_din[gi];
    end else begin : g_none
      assign pend4[gi]         = 1'b0;
      assign rd4[gi]           = 1'b0;
      assign pres4[gi]         = 1'b0;
      assign lba4[gi]          = 16'h0000;
      assign unused_lba_hi[gi] = 16'h0000;
      assign cnt4[gi]          = 6'd0;
      assign din4[gi]          = 8'h00;
    end
  end

  for (genvar gi = 0; gi < SUBDRV; gi++) begin : g_ack
    assign sd_ack[gi] = busy && (sel == 2'(gi));
  end

  // Round-robin: scan starting one past the drive served last.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = last;
    for (int k = 0; k < SUBDRV; k++) begin
      int t;
      t = int'(last) + 1 + k;
      if (t >= SUBDRV) t = t - SUBDRV;
      if (t >= SUBDRV) t = t - SUBDRV;
      if (!grant_ok && pend4[t[1:0]]) begin
        grant_ok  = 1'b1;
        grant_idx = t[1:0];
      end
    end
  end

  assign last_byte = (off[7:0] == 8'hFF) && (({1'b0, blk} + 7'd1) == cnt);

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    sd_buff_wr = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    adv        = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ok) state_nxt = START;
      end
      START: begin
        busy      = 1'b1;
        state_nxt = dir_wr ? WR_ADDR : RD_REQ;
      end
      RD_REQ: begin
        busy   = 1'b1;
        mem_rd = present;
        if (!present || mem_ready) state_nxt = RD_PUT;
      end
      RD_PUT: begin
        busy       = 1'b1;
        sd_buff_wr = 1'b1;
        adv        = 1'b1;
        state_nxt  = last_byte ? DONE : RD_REQ;
      end
      WR_ADDR: begin
        busy      = 1'b1;
        state_nxt = WR_SAMPLE;
      end
      WR_SAMPLE: begin
        busy      = 1'b1;
        state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        busy   = 1'b1;
        mem_wr = present;
        if (!present || mem_ready) begin
          adv       = 1'b1;
          state_nxt = last_byte ? DONE : WR_ADDR;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sel     <= 2'd0;
      last    <= 2'(SUBDRV - 1);
      dir_wr  <= 1'b0;
      present <= 1'b0;
      lba     <= 16'h0000;
      cnt     <= 7'd0;
      off     <= 13'd0;
      blk     <= 6'd0;
      rdata   <= 8'h00;
      wdata   <= 8'h00;
    end else begin
      if (state == IDLE && grant_ok) begin
        sel     <= grant_idx;
        dir_wr  <= ~rd4[grant_idx];
        present <= pres4[grant_idx];
        lba     <= lba4[grant_idx];
        cnt     <= {1'b0, cnt4[grant_idx]} + 7'd1;
        off     <= 13'd0;
        blk     <= 6'd0;
      end
      if (state == RD_REQ && (!present || mem_ready))
        rdata <= present ? mem_dout : 8'h00;
      if (state == WR_SAMPLE)
        wdata <= din4[sel];
      if (adv) begin
        off <= off + 13'd1;
        if (off[7:0] == 8'hFF) blk <= blk + 6'd1;
      end
      if (state == DONE)
        last <= sel;
    end
  end

  assign sd_buff_addr = off;
  assign sd_buff_dout = rdata;
  assign mem_din      = wdata;
  assign mem_addr     = {sel, lba + {10'd0, blk}, off[7:0]};

endmodule

// File: tb/tb_ieeedrv_img_server.sv
// tb/tb_ieeedrv_img_server.sv - scoreboard bench for ieeedrv_img_server
module tb_ieeedrv_img_server;
  localparam int SUBDRV = 2;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic [SUBDRV-1:0] img_present = '1;
  logic [31:0]       sd_lba [SUBDRV];
  logic [5:0]        sd_blk_cnt [SUBDRV];
  logic [SUBDRV-1:0] sd_rd = '0;
  logic [SUBDRV-1:0] sd_wr = '0;
  logic [SUBDRV-1:0] sd_ack;
  logic [12:0]       sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic [7:0]        sd_buff_din [SUBDRV];
  logic              sd_buff_wr;
  logic [25:0]       mem_addr;
  logic              mem_rd, mem_wr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout = 8'h00;
  logic              mem_ready = 1'b0;

  ieeedrv_img_server #(.SUBDRV(SUBDRV)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_present(img_present),
    .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_ready(mem_ready)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { logic [1:0] ack; logic [12:0] addr; logic [7:0] data; } strobe_t;
  typedef struct { logic [25:0] addr; logic [7:0] data; } wr_t;
  strobe_t     strobe_q[$];
  logic [25:0] rd_q[$];
  wr_t         wr_q[$];

  int checks = 0, errors = 0;
  int mem_mode = 0;
  bit wait_mode = 0;
  int rd_post [SUBDRV] = '{default: 0};
  int wr_post [SUBDRV] = '{default: 0};
  int rd_done [SUBDRV] = '{default: 0};
  int wr_done [SUBDRV] = '{default: 0};
  logic [SUBDRV-1:0] ack_q = '0;
  int ack_cyc = 0, strobe_cnt = 0, mem_rd_cyc = 0, mem_wr_cyc = 0;
  logic prev_wr = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(logic [25:0] a);
    if (mem_mode == 0) return a[7:0];
    return a[7:0] ^ a[15:8] ^ {a[25:24], 6'b0} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] din_pat(int d, logic [12:0] a);
    return ~a[7:0] ^ (8'(d) * 8'h5A);
  endfunction

  function automatic bit pending();
    for (int i = 0; i < SUBDRV; i++)
      if (rd_post[i] != rd_done[i] || wr_post[i] != wr_done[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Drive model: holds each request until its ack rises, presents buffer bytes.
  always @(negedge clk_sys) begin
    for (int i = 0; i < SUBDRV; i++) begin
      if (sd_ack[i] && !ack_q[i]) begin
        if (sd_rd[i]) rd_done[i]++;
        else if (sd_wr[i]) wr_done[i]++;
      end
      sd_rd[i] = (rd_post[i] != rd_done[i]);
      sd_wr[i] = (wr_post[i] != wr_done[i]);
      sd_buff_din[i] = din_pat(i, sd_buff_addr);
    end
    ack_q = sd_ack;
  end

  // Image memory model with optional random wait states.
  always @(negedge clk_sys) begin
    mem_ready = wait_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_dout  = mem_rd ? mem_byte(mem_addr) : 8'($urandom);
    if (mem_rd) mem_rd_cyc++;
    if (mem_wr) mem_wr_cyc++;
    if (mem_rd && mem_ready) begin
      if (rd_q.size() == 0) check("mem_rd_extra", 1, 0);
      else check("mem_rd_addr", 32'(mem_addr), 32'(rd_q.pop_front()));
    end
    if (mem_wr && mem_ready) begin
      if (wr_q.size() == 0) check("mem_wr_extra", 1, 0);
      else begin
        wr_t w;
        w = wr_q.pop_front();
        check("mem_wr_addr", 32'(mem_addr), 32'(w.addr));
        check("mem_wr_din", 32'(mem_din), 32'(w.data));
      end
    end
  end

  // Buffer-side monitor.
  always @(negedge clk_sys) begin
    if (sd_ack != '0) begin
      ack_cyc++;
      check("ack_onehot", $countones(sd_ack), 1);
    end
    if (sd_buff_wr) begin
      strobe_cnt++;
      check("wr_gap", 32'(prev_wr), 0);
      if (strobe_q.size() == 0) check("strobe_extra", 1, 0);
      else begin
        strobe_t s;
        s = strobe_q.pop_front();
        check("buff_addr", 32'(sd_buff_addr), 32'(s.addr));
        check("buff_dout", 32'(sd_buff_dout), 32'(s.data));
        check("strobe_ack", 32'(sd_ack), 32'(s.ack));
      end
    end
    prev_wr = sd_buff_wr;
  end

  task automatic issue_read(int d, logic [31:0] lba, logic [5:0] bc);
    sd_lba[d] = lba;
    sd_blk_cnt[d] = bc;
    for (int b = 0; b <= int'(bc); b++)
      for (int n = 0; n < 256; n++) begin
        logic [25:0] a;
        strobe_t s;
        a = {2'(d), lba[15:0] + 16'(b), 8'(n)};
        s.ack = 2'(1 << d);
        s.addr = 13'(b * 256 + n);
        s.data = img_present[d] ? mem_byte(a) : 8'h00;
        strobe_q.push_back(s);
        if (img_present[d]) rd_q.push_back(a);
      end
    rd_post[d]++;
  endtask

  task automatic issue_write(int d, logic [31:0] lba, logic [5:0] bc);
    sd_lba[d] = lba;
    sd_blk_cnt[d] = bc;
    for (int b = 0; b <= int'(bc); b++)
      for (int n = 0; n < 256; n++) begin
        wr_t w;
        w.addr = {2'(d), lba[15:0] + 16'(b), 8'(n)};
        w.data = din_pat(d, 13'(b * 256 + n));
        if (img_present[d]) wr_q.push_back(w);
      end
    wr_post[d]++;
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < 40000) begin
      @(negedge clk_sys);
      n++;
      ok = (n >= 3) && !pending() && sd_ack == '0 &&
           strobe_q.size() == 0 && rd_q.size() == 0 && wr_q.size() == 0;
    end
    check({tag, "_complete"}, 32'(ok), 1);
    if (!ok) begin
      strobe_q.delete();
      rd_q.delete();
      wr_q.delete();
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
  endtask

  int a0, m0, a_lat, w_lat, s0;

  initial begin
    for (int i = 0; i < SUBDRV; i++) begin
      sd_lba[i] = 32'd0;
      sd_blk_cnt[i] = 6'd0;
      sd_buff_din[i] = 8'h00;
    end
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_ack", 32'(sd_ack), 0);
    check("rst_buff_wr", 32'(sd_buff_wr), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_buff_addr", 32'(sd_buff_addr), 0);
    check("rst_buff_dout", 32'(sd_buff_dout), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_din", 32'(mem_din), 0);
    @(posedge clk_sys);
    #1 reset = 1'b0;
    @(posedge clk_sys);
    #1;

    // Single-block read with latency measurement.
    a0 = ack_cyc; a_lat = 0; w_lat = 0;
    issue_read(0, 32'd357, 6'd0);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk_sys);
      if (sd_ack[0] && a_lat == 0) a_lat = n;
      if (sd_buff_wr && w_lat == 0) w_lat = n;
    end
    check("ack_latency", 32'(a_lat), 2);
    check("first_strobe", 32'(w_lat), 4);
    wait_idle("rd1");
    check("rd1_ack_cycles", 32'(ack_cyc - a0), 513);

    // Multi-block read on drive 1 with random memory waits.
    mem_mode = 1; wait_mode = 1;
    issue_read(1, 32'd10, 6'd3);
    wait_idle("rd4");
    wait_mode = 0;

    // Two-block write, zero wait.
    a0 = ack_cyc;
    issue_write(0, 32'd5, 6'd1);
    wait_idle("wr2");
    check("wr2_ack_cycles", 32'(ack_cyc - a0), 1537);

    // Simultaneous requests after reset, then with drive 0 last served.
    pulse_reset();
    issue_read(0, 32'd100, 6'd0);
    issue_read(1, 32'd200, 6'd0);
    wait_idle("sim_a");
    issue_read(0, 32'd300, 6'd0);
    wait_idle("sim_b0");
    issue_read(1, 32'd400, 6'd0);
    issue_read(0, 32'd500, 6'd0);
    wait_idle("sim_b");

    // Image absent on drive 1.
    img_present = 2'b01;
    a0 = ack_cyc; m0 = mem_rd_cyc;
    issue_read(1, 32'd7, 6'd0);
    wait_idle("abs_rd");
    check("abs_rd_mem_rd", 32'(mem_rd_cyc - m0), 0);
    check("abs_rd_ack_cycles", 32'(ack_cyc - a0), 513);
    a0 = ack_cyc; m0 = mem_wr_cyc;
    issue_write(1, 32'd7, 6'd0);
    wait_idle("abs_wr");
    check("abs_wr_mem_wr", 32'(mem_wr_cyc - m0), 0);
    check("abs_wr_ack_cycles", 32'(ack_cyc - a0), 769);
    img_present = 2'b11;

    // LBA wraps at 16 bits, upper bits ignored.
    issue_read(0, 32'h1234_FFFF, 6'd1);
    wait_idle("lba_wrap");

    // 33 blocks: buffer offset wraps modulo 8192.
    a0 = ack_cyc;
    issue_read(1, 32'd1000, 6'd32);
    wait_idle("big");
    check("big_ack_cycles", 32'(ack_cyc - a0), 16897);

    // Reset in the middle of a read.
    s0 = strobe_cnt;
    issue_read(0, 32'd50, 6'd0);
    for (int n = 0; n < 2000 && strobe_cnt < s0 + 100; n++) @(posedge clk_sys);
    check("mid_reached", 32'(strobe_cnt - s0), 100);
    #1 reset = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("mid_rst_ack", 32'(sd_ack), 0);
    check("mid_rst_mem_rd", 32'(mem_rd), 0);
    check("mid_rst_buff_wr", 32'(sd_buff_wr), 0);
    strobe_q.delete();
    rd_q.delete();
    @(posedge clk_sys);
    #1 reset = 1'b0;
    @(posedge clk_sys);
    #1;
    s0 = strobe_cnt;
    issue_read(0, 32'd60, 6'd0);
    wait_idle("post_rst");
    check("post_rst_strobes", 32'(strobe_cnt - s0), 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
